// File: rtl/if_id_skid_reg.sv
// ---------------------------------------------------------------------------
// if_id_skid_reg
//   IF->ID pipeline register with a valid/ready handshake and a 2-entry skid
//   buffer. The main entry drives the ID outputs. The skid entry catches the
//   beat that arrives in the cycle ID stalls. if_ready_o is a plain flop, so
//   ID back-pressure never reaches the IF path combinationally. flush_i kills
//   every held beat and any incoming beat, which leaves a NOP bubble on ID.
//
// Ports
//   clk         in   1       clock, rising edge
//   rst         in   1       asynchronous reset, active low
//   flush_i     in   1       synchronous kill of held and incoming beats
//   if_valid_i  in   1       IF presents a beat
//   if_ready_o  out  1       stage can accept a beat (registered)
//   addr_i      in   ADDR_W  fetch address of the incoming beat
//   inst_i      in   INST_W  instruction of the incoming beat
//   id_valid_o  out  1       head beat valid toward ID
//   id_ready_i  in   1       ID consumes the head beat this cycle
//   addr_o      out  ADDR_W  address of the head beat
//   inst_o      out  INST_W  instruction of the head beat, NOP_INST when idle
// ---------------------------------------------------------------------------
module if_id_skid_reg #(
   parameter int                 ADDR_W     = 32,
   parameter int                 INST_W     = 32,
   parameter logic [INST_W-1:0]  NOP_INST   = '0,
   parameter logic [ADDR_W-1:0]  RESET_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              if_valid_i,
   output logic              if_ready_o,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [INST_W-1:0] inst_i,
   output logic              id_valid_o,
   input  logic              id_ready_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic [INST_W-1:0] inst_o
);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [INST_W-1:0] inst;
   } beat_t;

   beat_t m_beat, s_beat, in_beat;
   logic  m_v, s_v, rdy_q;
   logic  m_v_d, s_v_d;
   logic  m_ld, m_from_s, s_ld;
   logic  acc, deq;

   assign in_beat = '{addr: addr_i, inst: inst_i};
   assign acc     = if_valid_i & rdy_q;
   assign deq     = m_v & id_ready_i;

   // Entry control. Data registers load only on their own load strobe, so a
   // held beat stays bit-stable until it is dequeued.
   always_comb begin
      m_v_d    = m_v;
      s_v_d    = s_v;
      m_ld     = 1'b0;
      m_from_s = 1'b0;
      s_ld     = 1'b0;
      if (flush_i) begin
         // A dequeue in this cycle still completes on the ID side. A beat
         // accepted in this cycle is dropped.
         m_v_d = 1'b0;
         s_v_d = 1'b0;
      end else if (s_v) begin
         // When the skid entry is full, rdy_q is low, so acc cannot be set.
         if (deq) begin
            m_ld     = 1'b1;
            m_from_s = 1'b1;
            m_v_d    = 1'b1;
            s_v_d    = 1'b0;
         end
      end else if (!m_v || deq) begin
         m_ld  = acc;
         m_v_d = acc;
      end else if (acc) begin
         // Main entry is stalled, so the incoming beat parks in the skid entry.
         s_ld  = 1'b1;
         s_v_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_v   <= 1'b0;
         s_v   <= 1'b0;
         rdy_q <= 1'b1;
      end else begin
         m_v   <= m_v_d;
         s_v   <= s_v_d;
         // Registered copy of !s_v, so ready never depends on id_ready_i
         // within the same cycle.
         rdy_q <= ~s_v_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_beat <= '{addr: RESET_ADDR, inst: NOP_INST};
         s_beat <= '{addr: RESET_ADDR, inst: NOP_INST};
      end else begin
         if (m_ld) m_beat <= m_from_s ? s_beat : in_beat;
         if (s_ld) s_beat <= in_beat;
      end
   end

   assign if_ready_o = rdy_q;
   assign id_valid_o = m_v;
   assign addr_o     = m_beat.addr;
   assign inst_o     = m_v ? m_beat.inst : NOP_INST;

endmodule

// File: tb/tb_if_id_skid_reg.sv
module tb_if_id_skid_reg;

   localparam int          AW  = 32;
   localparam int          IW  = 32;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] RA  = 32'h0000_0F00;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          flush_i = 1'b0, if_valid_i = 1'b0, id_ready_i = 1'b0;
   logic          if_ready_o, id_valid_o;
   logic [AW-1:0] addr_i = '0, addr_o;
   logic [IW-1:0] inst_i = '0, inst_o;

   int total = 0;
   int passed = 0;

   if_id_skid_reg #(.ADDR_W(AW), .INST_W(IW), .NOP_INST(NOP), .RESET_ADDR(RA)) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i),
      .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
      .addr_i(addr_i), .inst_i(inst_i),
      .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
      .addr_o(addr_o), .inst_o(inst_o)
   );

   always #5 clk = ~clk;

   // Each instruction word is derived from its address so that a beat can be
   // told apart by either field.
   function automatic logic [31:0] mk_inst(input logic [31:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endtask

   typedef struct {
      logic        flush;
      logic        vld;
      logic [31:0] addr;
      logic        rdy;
      logic        e_idv;   // expected id_valid_o after the edge
      logic        e_ifr;   // expected if_ready_o after the edge
      logic [31:0] e_addr;  // expected head address, checked only when e_idv is set
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mv(input logic f, input logic v, input logic [31:0] a,
                               input logic r, input logic eiv, input logic eir,
                               input logic [31:0] ea);
      vec_t t;
      t.flush = f; t.vld = v; t.addr = a; t.rdy = r;
      t.e_idv = eiv; t.e_ifr = eir; t.e_addr = ea;
      return t;
   endfunction

   task automatic apply(input vec_t t, input string tag);
      @(negedge clk);
      flush_i = t.flush; if_valid_i = t.vld; addr_i = t.addr;
      inst_i = mk_inst(t.addr); id_ready_i = t.rdy;
      @(posedge clk); #1;
      chk({tag, ".id_valid"}, {31'b0, id_valid_o}, {31'b0, t.e_idv});
      chk({tag, ".if_ready"}, {31'b0, if_ready_o}, {31'b0, t.e_ifr});
      if (t.e_idv) begin
         chk({tag, ".addr"}, addr_o, t.e_addr);
         chk({tag, ".inst"}, inst_o, mk_inst(t.e_addr));
      end else begin
         chk({tag, ".nop"}, inst_o, NOP);
      end
   endtask

   logic [63:0] sb[$];
   logic [31:0] next_addr, held_addr;
   logic        acc, deq, hold_prev;

   initial begin
      // Streaming at full rate: each beat appears one cycle after it is sent.
      for (int k = 0; k < 10; k++)
         vt.push_back(mv(0, 1, 32'h100 + 4*k, 1, 1, 1, 32'h100 + 4*k));
      vt.push_back(mv(0, 0, 32'hDEAD, 1, 0, 1, 0));
      // Skid: the second beat parks in the skid entry and ready drops.
      vt.push_back(mv(0, 1, 32'h100, 0, 1, 1, 32'h100));
      vt.push_back(mv(0, 1, 32'h104, 0, 1, 0, 32'h100));
      vt.push_back(mv(0, 1, 32'h108, 0, 1, 0, 32'h100));  // not accepted
      vt.push_back(mv(0, 0, 32'h0,   1, 1, 1, 32'h104));
      vt.push_back(mv(0, 0, 32'h0,   1, 0, 1, 0));
      // Flush with the skid entry full.
      vt.push_back(mv(0, 1, 32'h200, 0, 1, 1, 32'h200));
      vt.push_back(mv(0, 1, 32'h204, 0, 1, 0, 32'h200));
      vt.push_back(mv(1, 1, 32'h208, 0, 0, 1, 0));
      vt.push_back(mv(0, 0, 32'h0,   1, 0, 1, 0));
      // Flush while a beat is accepted in the same cycle: that beat is dropped.
      vt.push_back(mv(0, 1, 32'h300, 0, 1, 1, 32'h300));
      vt.push_back(mv(1, 1, 32'h304, 1, 0, 1, 0));
      vt.push_back(mv(0, 0, 32'h0,   1, 0, 1, 0));
      vt.push_back(mv(0, 0, 32'h0,   1, 0, 1, 0));

      // Reset with garbage on the inputs.
      flush_i = 1'b1; if_valid_i = 1'b1; id_ready_i = 1'b1;
      addr_i = 32'hFFFF_FFFF; inst_i = 32'hFFFF_FFFF;
      #12;
      chk("rst.id_valid", {31'b0, id_valid_o}, 32'd0);
      chk("rst.if_ready", {31'b0, if_ready_o}, 32'd1);
      chk("rst.addr", addr_o, RA);
      chk("rst.inst", inst_o, NOP);
      @(negedge clk);
      flush_i = 1'b0; if_valid_i = 1'b0; id_ready_i = 1'b0;
      rst = 1'b1;

      for (int i = 0; i < vt.size(); i++) apply(vt[i], $sformatf("vec%0d", i));

      // Random valid/ready traffic checked against a scoreboard queue.
      next_addr = 32'h1000;
      hold_prev = 1'b0;
      held_addr = '0;
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk);
         flush_i    = 1'b0;
         if_valid_i = ($urandom_range(0, 3) != 0);
         id_ready_i = ($urandom_range(0, 2) != 0);
         addr_i     = next_addr;
         inst_i     = ~next_addr;
         #1;
         if (id_valid_o !== (sb.size() != 0))
            chk("rnd.id_valid", {31'b0, id_valid_o}, {31'b0, sb.size() != 0});
         if (if_ready_o !== (sb.size() < 2))
            chk("rnd.if_ready", {31'b0, if_ready_o}, {31'b0, sb.size() < 2});
         if (hold_prev) chk("rnd.stable", addr_o, held_addr);
         acc = if_valid_i & if_ready_o;
         deq = id_valid_o & id_ready_i;
         if (deq) begin
            if (sb.size() == 0) chk("rnd.spurious", 32'd1, 32'd0);
            else begin
               chk("rnd.addr", addr_o, sb[0][63:32]);
               chk("rnd.inst", inst_o, sb[0][31:0]);
               void'(sb.pop_front());
            end
         end
         hold_prev = id_valid_o & ~id_ready_i;
         held_addr = addr_o;
         if (acc) begin
            sb.push_back({next_addr, ~next_addr});
            next_addr += 4;
         end
      end

      // Asynchronous reset pulse while the skid entry is full.
      apply(mv(1, 0, 32'h0,   0, 0, 1, 0), "pre6");
      apply(mv(0, 1, 32'h500, 0, 1, 1, 32'h500), "r6a");
      apply(mv(0, 1, 32'h504, 0, 1, 0, 32'h500), "r6b");
      @(negedge clk);
      if_valid_i = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("arst.id_valid", {31'b0, id_valid_o}, 32'd0);
      chk("arst.if_ready", {31'b0, if_ready_o}, 32'd1);
      chk("arst.addr", addr_o, RA);
      chk("arst.inst", inst_o, NOP);
      @(negedge clk);
      rst = 1'b1;
      apply(mv(0, 0, 32'h0, 1, 0, 1, 0), "post6a");
      apply(mv(0, 0, 32'h0, 1, 0, 1, 0), "post6b");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
